// File: rtl/mem_sram_pkg.sv
// Shared types and helpers for the word-addressed SRAM bank: bus widths, response record, address decode.
// Widths are fixed here so the response record stays a plain packed struct across the slice.
package mem_sram_pkg;

    localparam int unsigned AddrWidth  = 5;
    localparam int unsigned DataWidth  = 32;
    localparam int unsigned BeWidth    = DataWidth / 8;
    localparam int unsigned OffsetBits = (BeWidth > 1) ? $clog2(BeWidth) : 0;

    typedef struct packed {
        logic                 valid;
        logic                 err;
        logic [DataWidth-1:0] rdata;
    } rsp_t;

    // Byte address to word index; sub-word offset bits are dropped, aligning down.
    function automatic logic [AddrWidth-1:0] word_idx(input logic [AddrWidth-1:0] addr);
        return addr >> OffsetBits;
    endfunction

endpackage

// File: rtl/mem_sram_rsp_pipe.sv
// Fixed-depth response delay line: Latency stages of rsp_t, cleared by async reset.
// Latency: Latency cycles input-to-output. No backpressure; one entry shifts every cycle.
// Reset discards every in-flight response immediately.
module mem_sram_rsp_pipe
    import mem_sram_pkg::*;
#(
    parameter int unsigned Latency = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  rsp_t i_rsp,
    output rsp_t o_rsp
);

    rsp_t r_stage [Latency];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Latency; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_rsp;
            for (int i = 1; i < Latency; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_rsp = r_stage[Latency-1];

endmodule

// File: rtl/mem_sram_bank.sv
// Word-addressed SRAM bank with byte enables; one response per granted request, reads and writes alike.
// Latency: rvalid_o pulses Latency cycles after the grant edge; back-to-back grants give back-to-back pulses.
// Backpressure: none on responses; gnt_o is constant 1, or periodically low when MEM_SRAM_STALL_EN is defined.
module mem_sram_bank
    import mem_sram_pkg::*;
#(
    parameter int unsigned NumWords    = 8,
    parameter int unsigned Latency     = 1,
    parameter int unsigned StallPeriod = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic                 we_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeWidth-1:0]   be_i,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 err_o
);

    localparam int unsigned IdxWidth = (NumWords > 1) ? $clog2(NumWords) : 1;

    logic [DataWidth-1:0] r_mem [NumWords];

    logic                 w_fire;
    logic [AddrWidth-1:0] w_idx;
    logic [IdxWidth-1:0]  w_idx_mem;
    logic                 w_in_range;
    rsp_t                 w_rsp_in;
    rsp_t                 w_rsp_out;

`ifdef MEM_SRAM_STALL_EN
    localparam int unsigned CntWidth = (StallPeriod > 1) ? $clog2(StallPeriod) : 1;
    localparam logic [CntWidth-1:0] StallCount = CntWidth'(StallPeriod - 1);

    logic [CntWidth-1:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (r_stall_cnt == StallCount) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + CntWidth'(1);
        end
    end

    assign gnt_o = rst_ni && (r_stall_cnt != StallCount);
`else
    assign gnt_o = 1'b1;
`endif

    assign w_fire     = req_i && gnt_o;
    assign w_idx      = word_idx(addr_i);
    assign w_idx_mem  = w_idx[IdxWidth-1:0];
    assign w_in_range = (32'(w_idx) < NumWords);

    // Storage is deliberately left unreset so it maps onto plain RAM resources.
    always_ff @(posedge clk_i) begin
        if (w_fire && we_i && w_in_range) begin
            for (int b = 0; b < BeWidth; b++) begin
                if (be_i[b]) begin
                    r_mem[w_idx_mem][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Read data is captured at the grant edge, so a read right after a write sees the new word.
    always_comb begin
        w_rsp_in = '0;
        if (w_fire) begin
            w_rsp_in.valid = 1'b1;
            w_rsp_in.err   = !w_in_range;
            if (!we_i && w_in_range) begin
                w_rsp_in.rdata = r_mem[w_idx_mem];
            end
        end
    end

    mem_sram_rsp_pipe #(
        .Latency (Latency)
    ) u_rsp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_rsp  (w_rsp_in),
        .o_rsp  (w_rsp_out)
    );

    assign rvalid_o = w_rsp_out.valid;
    assign err_o    = w_rsp_out.err;
    assign rdata_o  = w_rsp_out.rdata;

endmodule

// File: tb/tb_mem_sram_bank.sv
// Bench for mem_sram_bank (NumWords=6, Latency=3): directed vector table, hand sequences, and random traffic vs a word-array model.
// Honours MEM_SRAM_STALL_EN for the expected grant pattern.
module tb_mem_sram_bank;

    localparam int NW  = 6;
    localparam int LAT = 3;
`ifdef MEM_SRAM_STALL_EN
    localparam int STALL = 4;
`endif

    logic        clk_i;
    logic        rst_ni;
    logic        req_i;
    logic        gnt_o;
    logic [4:0]  addr_i;
    logic        we_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    mem_sram_bank #(
        .NumWords    (NW),
        .Latency     (LAT),
        .StallPeriod (4)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .wdata_i  (wdata_i),
        .be_i     (be_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o)
    );

    typedef struct {
        bit        we;
        bit [4:0]  addr;
        bit [31:0] wdata;
        bit [3:0]  be;
        bit [31:0] exp_rdata;
        bit        exp_err;
    } vec_t;

    typedef struct {
        int        due;
        bit        err;
        bit [31:0] rdata;
        int        tag;
    } exp_t;

    vec_t      tbl [18];
    exp_t      exp_q [$];
    bit [31:0] m_mem [NW];

    int n_cmp   = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int edges   = 0;
    int n_fired = 0;
    int n_seen  = 0;
    int n_disc  = 0;
    int cur_tag = -1;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) begin
        cyc++;
        if (!rst_ni) edges = 0;
        else         edges++;
    end

    function automatic bit model_gnt();
`ifdef MEM_SRAM_STALL_EN
        return rst_ni && ((edges % STALL) != STALL - 1);
`else
        return 1'b1;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: retire responses, then predict the response of this cycle's grant.
    always @(negedge clk_i) begin
        exp_t e;
        int   idx;
        if (!rst_ni) begin
            n_disc += exp_q.size();
            exp_q.delete();
        end else begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_missing: no rvalid by cycle %0d, expected at %0d", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (rvalid_o) begin
                n_seen++;
                if (exp_q.size() == 0) begin
                    check("rvalid_unexpected", 32'(rvalid_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_cycle", cyc, e.due);
                    check("rsp_err", 32'(err_o), 32'(e.err));
                    check("rsp_rdata", rdata_o, e.rdata);
                    if (e.tag >= 0) begin
                        check($sformatf("tbl%0d_err", e.tag), 32'(err_o), 32'(tbl[e.tag].exp_err));
                        check($sformatf("tbl%0d_rdata", e.tag), rdata_o, tbl[e.tag].exp_rdata);
                    end
                end
            end
            check("gnt", 32'(gnt_o), 32'(model_gnt()));
            if (req_i && model_gnt()) begin
                idx     = int'(addr_i) / 4;
                e.due   = cyc + LAT;
                e.tag   = cur_tag;
                e.err   = (idx >= NW);
                e.rdata = '0;
                if (!e.err) begin
                    if (we_i) begin
                        for (int b = 0; b < 4; b++)
                            if (be_i[b]) m_mem[idx][8*b +: 8] = wdata_i[8*b +: 8];
                    end else begin
                        e.rdata = m_mem[idx];
                    end
                end
                exp_q.push_back(e);
                n_fired++;
            end
        end
    end

    // Entered and left at 1 time unit after a rising edge; holds the request until granted.
    task automatic do_req(input bit we, input bit [4:0] a, input bit [31:0] d, input bit [3:0] be, input int tag);
        bit done = 1'b0;
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = a;
        wdata_i = d;
        be_i    = be;
        cur_tag = tag;
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk_i);
            done = model_gnt();
            @(posedge clk_i);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant_timeout: addr %h not granted within 8 cycles", a);
        end
        req_i   = 1'b0;
        cur_tag = -1;
    endtask

    task automatic idle(input int n);
        req_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [31:0] d;
        bit        hit;

        tbl[0]  = '{1'b1, 5'h00, 32'h12345678, 4'hF, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 5'h00, 32'hCAFEF00D, 4'h8, 32'h0,        1'b0};
        tbl[2]  = '{1'b0, 5'h00, 32'h0,        4'h0, 32'hCA345678, 1'b0};
        tbl[3]  = '{1'b1, 5'h04, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 5'h04, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tbl[5]  = '{1'b1, 5'h08, 32'h11223344, 4'hF, 32'h0,        1'b0};
        tbl[6]  = '{1'b1, 5'h08, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        tbl[7]  = '{1'b0, 5'h08, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        tbl[8]  = '{1'b0, 5'h0B, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
        tbl[9]  = '{1'b1, 5'h14, 32'h55667788, 4'hF, 32'h0,        1'b0};
        tbl[10] = '{1'b0, 5'h14, 32'h0,        4'h0, 32'h55667788, 1'b0};
        tbl[11] = '{1'b0, 5'h18, 32'h0,        4'h0, 32'h0,        1'b1};
        tbl[12] = '{1'b1, 5'h18, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        tbl[13] = '{1'b1, 5'h1C, 32'h0,        4'hF, 32'h0,        1'b1};
        tbl[14] = '{1'b0, 5'h1C, 32'h0,        4'h0, 32'h0,        1'b1};
        tbl[15] = '{1'b1, 5'h04, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        tbl[16] = '{1'b0, 5'h07, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tbl[17] = '{1'b0, 5'h14, 32'h0,        4'h0, 32'h55667788, 1'b0};

        rst_ni  = 1'b0;
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        be_i    = '0;
        #2;
        check("rst_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_gnt", 32'(gnt_o), 32'(model_gnt()));
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // Directed vectors, issued back to back.
        for (int i = 0; i < 18; i++)
            do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, i);
        idle(LAT + 2);

        // Streamed writes across the whole address space, then streamed reads.
        for (int i = 0; i < 8; i++) do_req(1'b1, 5'(i * 4), $urandom, 4'hF, -1);
        for (int i = 0; i < 8; i++) do_req(1'b0, 5'(i * 4), 32'h0, 4'h0, -1);
        idle(LAT + 2);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            d = $urandom;
            do_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), d, 4'($urandom_range(0, 15)), -1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(LAT + 2);

        // Reset with two reads in flight: the visible response must drop at once, none may follow.
        do_req(1'b0, 5'h04, 32'h0, 4'h0, -1);
        do_req(1'b0, 5'h08, 32'h0, 4'h0, -1);
        hit = rvalid_o;
        for (int k = 0; k < 6 && !hit; k++) begin
            @(posedge clk_i);
            #1 hit = rvalid_o;
        end
        check("rvalid_before_rst", 32'(rvalid_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("rst_async_rvalid", 32'(rvalid_o), 32'd0);
        check("rst_async_rdata", rdata_o, 32'd0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        idle(LAT + 3);

        // Array survives reset; a write then read still behaves.
        do_req(1'b0, 5'h14, 32'h0, 4'h0, -1);
        do_req(1'b1, 5'h10, 32'h0BADF00D, 4'h3, -1);
        do_req(1'b0, 5'h10, 32'h0, 4'h0, -1);
        idle(LAT + 3);

        check("pulse_count", n_seen, n_fired - n_disc);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_sram_bank.md
Name: mem_sram_bank

Overview:
Word-addressed synchronous SRAM bank with byte enables. Sits directly downstream of axi_top on its memory-side port: it consumes mem_req_o/addr/we/wdata/strb and returns rdata/rvalid/err. One response is returned per granted request, for both reads and writes, after a fixed latency. It serves as the bench and FPGA memory behind the AXI-to-mem path.

Parameters:
AddrWidth, 5, byte-address width; matches axi_top MemAddrWidth.
DataWidth, 32, data width in bits; a multiple of 8.
NumWords, 8, depth in words; must satisfy NumWords*(DataWidth/8) <= 2**AddrWidth.
Latency, 1, grant-to-rvalid cycles; range 1..4.
StallPeriod, 4, grant deassert period used only when MEM_SRAM_STALL_EN is defined; must be >= 2.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_ni  in  1  asynchronous active-low reset.
req_i  in  1  request valid.
gnt_o  out  1  request accepted this cycle when req_i && gnt_o.
addr_i  in  AddrWidth  byte address.
we_i  in  1  1 = write, 0 = read.
wdata_i  in  DataWidth  write data.
be_i  in  DataWidth/8  byte enables for writes; ignored on reads.
rvalid_o  out  1  response valid; single-cycle pulse per granted request.
rdata_o  out  DataWidth  read data; 0 for writes and errored accesses.
err_o  out  1  access error; qualified by rvalid_o.

Behaviour:
- Reset (asynchronous, rst_ni=0): rvalid_o=0, rdata_o=0, err_o=0, response pipeline cleared, stall counter=0. gnt_o=1 (0 while in reset under MEM_SRAM_STALL_EN). The memory array is not reset, so contents are undefined until written.
- Word index = addr_i >> log2(DataWidth/8). Low address bits are ignored, so misaligned addresses are aligned down.
- Out-of-range access (index >= NumWords): no array write, rdata=0, err=1 on the response.
- Write: on grant, for each byte b with be_i[b]=1, mem[idx][b] <= wdata_i[b]. Bytes with be_i[b]=0 keep their value. The response has rdata=0, err=0 unless out of range.
- Read: the array is sampled at the grant edge and the data travels down the pipeline.
- Latency: a request granted at edge N produces rvalid_o=1 during the cycle after edge N+Latency-1. With Latency=1, rvalid is high in the cycle right after the grant cycle.
- Back-to-back grants give back-to-back rvalid pulses. Throughput is 1 per cycle, with no response backpressure.
- Read-after-write to the same word in consecutive cycles returns the newly written data (the write commits at edge N; the read samples at edge N+1).
- Responses stay in grant order.
- Reset asserted mid-operation discards all in-flight responses; rvalid_o falls asynchronously.

Optional Feature:
MEM_SRAM_STALL_EN
- Defined: a free-running counter modulo StallPeriod drives gnt_o=0 when the count equals StallPeriod-1, otherwise gnt_o=1. A request held during a stall cycle is granted on the next cycle. Used to exercise upstream stall handling.
- Undefined: gnt_o is constant 1 and no counter is instantiated.

Decomposition:
- Package mem_sram_pkg holds:
  - function word_idx(addr);
  - constant BeWidth = DataWidth/8;
  - typedef rsp_t {valid, err, rdata}.
- Sub-module mem_sram_rsp_pipe: a Latency-deep shift register of rsp_t with async-low reset. The top module holds the array, the grant/stall logic and the error decode.

Test Plan:
- Write 0xDEADBEEF to addr 0x04 (be=0xF), then read 0x04 -> rvalid exactly Latency cycles after the read grant, rdata=0xDEADBEEF, err=0.
- Write 0x11223344 to addr 0x08 (be=0xF), then write 0xAABBCCDD to 0x08 with be=0x5, then read -> 0x11BB33DD.
- Read addr 0x1C (index 7) -> valid data. With NumWords=6, read addr 0x18 -> err=1, rdata=0; a following write to 0x18 leaves index 0..5 contents unchanged.
- Stream 8 back-to-back writes to 0x00..0x1C, then 8 back-to-back reads -> 8 consecutive rvalid pulses in address order, with data matching the writes.
- Assert rst_ni low for 1 cycle with 2 reads in flight (Latency=3) -> rvalid_o=0 immediately and no stale responses after release.
- With MEM_SRAM_STALL_EN and StallPeriod=4, hold req_i high -> gnt_o pattern 1,1,1,0 repeating, and the number of rvalid pulses equals the number of grants.
